serial_rx_buffer: RTL and testbench

- Downstream stage of the serial receiver: consumes the receiver's parallel byte and its `ready` strobe, and queues bytes in a small FIFO.
- Presents bytes to the local consumer through a valid/take handshake in the `Clk` domain.
- `ready` is generated in the serial-clock domain, so this block synchronizes it and captures one byte per `ready` rising edge.
- Sits between the receiver output and any byte consumer (display, command decoder).

---
 rtl/serial_rx_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_serial_rx_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_buffer.sv
// -----------------------------------------------------------------------------
// serial_rx_buffer
//
// Downstream stage of the serial receiver. The receiver's byte-ready strobe
// (RdyIn) arrives from the serial-clock domain. This block synchronizes it
// into the Clk domain and captures one byte of PDin per RdyIn rising edge into
// a small FIFO. The stored bytes are offered to a local consumer through a
// show-ahead valid/take handshake.
//
// Optional build macro: RXBUF_PARITY_EN
//   When it is defined, the block stores the receiver parity-error flag
//   (ParErrIn) as a ninth FIFO bit. ErrOut then presents that bit aligned
//   with Dout.
//
// Ports:
//   Clk       in   system clock, all state on the rising edge
//   Rst_n     in   asynchronous active-low reset
//   PDin      in   [7:0] received byte, stable while RdyIn is high
//   RdyIn     in   receiver byte-ready strobe, asynchronous to Clk
//   Dout      out  [7:0] head-of-FIFO byte, meaningful when Valid=1
//   Valid     out  FIFO non-empty
//   Take      in   consumer pops the head when Valid & Take
//   Count     out  [ADDR_W:0] number of stored entries, 0..DEPTH
//   Full      out  Count == DEPTH
//   Overflow  out  sticky flag: a byte was dropped because the FIFO was full
//   ClrOvf    in   synchronous clear of Overflow (a new drop wins)
//   ParErrIn  in   receiver parity error        (RXBUF_PARITY_EN only)
//   ErrOut    out  parity flag of the head byte (RXBUF_PARITY_EN only)
// -----------------------------------------------------------------------------
module serial_rx_buffer #(
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [7:0]        PDin,
   input  logic              RdyIn,
   output logic [7:0]        Dout,
   output logic              Valid,
   input  logic              Take,
   output logic [ADDR_W:0]   Count,
   output logic              Full,
   output logic              Overflow,
   input  logic              ClrOvf
`ifdef RXBUF_PARITY_EN
   ,
   input  logic              ParErrIn,
   output logic              ErrOut
`endif
);

`ifdef RXBUF_PARITY_EN
   localparam int DW = 9;
`else
   localparam int DW = 8;
`endif

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   // Synchronizer and capture-edge detection
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   hist_r;
   logic                   rs_s;
   logic                   cap_s;

   // FIFO storage and state
   logic [DW-1:0]          mem_r [DEPTH];
   logic [ADDR_W-1:0]      wr_ptr_r;
   logic [ADDR_W-1:0]      rd_ptr_r;
   logic [ADDR_W:0]        count_r;
   logic                   ovf_r;
   logic                   valid_r;
   logic                   full_r;
   logic [DW-1:0]          dout_r;

   // Next-state terms
   logic [DW-1:0]          wr_data_s;
   logic                   empty_s;
   logic                   is_full_s;
   logic                   pop_s;
   logic                   wr_en_s;
   logic                   drop_s;
   logic [ADDR_W-1:0]      wr_ptr_nxt_s;
   logic [ADDR_W-1:0]      rd_ptr_nxt_s;
   logic [ADDR_W:0]        count_nxt_s;
   logic [DW-1:0]          head_s;
   logic [DW-1:0]          dout_nxt_s;
   logic                   ovf_nxt_s;

`ifdef RXBUF_PARITY_EN
   assign wr_data_s = {ParErrIn, PDin};
   assign ErrOut    = dout_r[8];
`else
   assign wr_data_s = PDin;
`endif

   assign rs_s  = sync_r[SYNC_STAGES-1];
   // The history flop resets high, so a strobe already high at reset
   // release is not treated as a new byte.
   assign cap_s = rs_s & ~hist_r;

   // RdyIn synchronizer chain plus the previous-rs history flop
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_r <= {SYNC_STAGES{1'b1}};
         hist_r <= 1'b1;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], RdyIn};
         hist_r <= rs_s;
      end
   end

   // FIFO storage array, written only on an accepted capture
   always_ff @(posedge Clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= wr_data_s;
      end
   end

   // Handshake decode, pointer/count update and registered head look-ahead
   always_comb begin
      empty_s      = (count_r == {(ADDR_W+1){1'b0}});
      is_full_s    = (count_r == FULL_CNT);
      pop_s        = ~empty_s & Take;
      // A full FIFO still accepts a byte when the head leaves on the same edge.
      wr_en_s      = cap_s & (~is_full_s | pop_s);
      drop_s       = cap_s & is_full_s & ~pop_s;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      count_nxt_s  = count_r;
      head_s       = {DW{1'b0}};
      dout_nxt_s   = {DW{1'b0}};
      ovf_nxt_s    = ovf_r;

      if (wr_en_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end

      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end

      case ({wr_en_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase

      // The new head is the byte being written when it lands at the next read
      // slot. This happens when the FIFO was empty, or when it drains to one
      // entry while a byte is written. Otherwise the new head comes from storage.
      if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_s = wr_data_s;
      end else begin
         head_s = mem_r[rd_ptr_nxt_s];
      end

      if (count_nxt_s == {(ADDR_W+1){1'b0}}) begin
         dout_nxt_s = {DW{1'b0}};
      end else begin
         dout_nxt_s = head_s;
      end

      // A drop in the same cycle as ClrOvf keeps the flag set.
      if (drop_s) begin
         ovf_nxt_s = 1'b1;
      end else if (ClrOvf) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = ovf_r;
      end
   end

   // FIFO control state and registered output view
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr_r <= {ADDR_W{1'b0}};
         rd_ptr_r <= {ADDR_W{1'b0}};
         count_r  <= {(ADDR_W+1){1'b0}};
         ovf_r    <= 1'b0;
         valid_r  <= 1'b0;
         full_r   <= 1'b0;
         dout_r   <= {DW{1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         count_r  <= count_nxt_s;
         ovf_r    <= ovf_nxt_s;
         valid_r  <= (count_nxt_s != {(ADDR_W+1){1'b0}});
         full_r   <= (count_nxt_s == FULL_CNT);
         dout_r   <= dout_nxt_s;
      end
   end

   assign Dout     = dout_r[7:0];
   assign Valid    = valid_r;
   assign Count    = count_r;
   assign Full     = full_r;
   assign Overflow = ovf_r;

endmodule

// File: tb/tb_serial_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_buffer
//
// Directed bench for serial_rx_buffer, which uses the default parameters.
// The bench pushes each byte it expects the FIFO to accept onto a scoreboard
// queue, and compares bytes popped from the queue against Dout at every pop.
// Inputs change and outputs are sampled 1 ns after the rising Clk edge.
// -----------------------------------------------------------------------------
module tb_serial_rx_buffer;

   logic       Clk;
   logic       Rst_n;
   logic [7:0] PDin;
   logic       RdyIn;
   logic [7:0] Dout;
   logic       Valid;
   logic       Take;
   logic [3:0] Count;
   logic       Full;
   logic       Overflow;
   logic       ClrOvf;
`ifdef RXBUF_PARITY_EN
   logic       ParErrIn;
   logic       ErrOut;
   logic       perr_q [$];
`endif

   int         checks;
   int         failures;
   logic [7:0] exp_q [$];
   logic [7:0] exp_b;

   serial_rx_buffer dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .PDin     (PDin),
      .RdyIn    (RdyIn),
      .Dout     (Dout),
      .Valid    (Valid),
      .Take     (Take),
      .Count    (Count),
      .Full     (Full),
      .Overflow (Overflow),
      .ClrOvf   (ClrOvf)
`ifdef RXBUF_PARITY_EN
      ,
      .ParErrIn (ParErrIn),
      .ErrOut   (ErrOut)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One RdyIn pulse, held for 4 cycles, then low long enough to re-arm.
   task automatic send_byte(input logic [7:0] b, input logic pe);
      PDin  = b;
`ifdef RXBUF_PARITY_EN
      ParErrIn = pe;
`else
      if (pe) PDin = b;
`endif
      RdyIn = 1'b1;
      tick(4);
      RdyIn = 1'b0;
      tick(3);
   endtask

   // Pop the scoreboard head and compare it with Dout. Then pulse Take once.
   task automatic pop_check(input string tag);
      check({tag, "_valid"}, {31'd0, Valid}, 32'd1);
      if (exp_q.size() > 0) begin
         exp_b = exp_q.pop_front();
         check(tag, {24'd0, Dout}, {24'd0, exp_b});
      end else begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end
`ifdef RXBUF_PARITY_EN
      if (perr_q.size() > 0) check({tag, "_err"}, {31'd0, ErrOut}, {31'd0, perr_q.pop_front()});
`endif
      Take = 1'b1;
      tick(1);
      Take = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      Rst_n    = 1'b0;
      RdyIn    = 1'b1;
      PDin     = 8'hA5;
      Take     = 1'b0;
      ClrOvf   = 1'b0;
`ifdef RXBUF_PARITY_EN
      ParErrIn = 1'b0;
`endif
      tick(3);
      check("rst_valid",    {31'd0, Valid},    32'd0);
      check("rst_count",    {28'd0, Count},    32'd0);
      check("rst_dout",     {24'd0, Dout},     32'd0);
      check("rst_overflow", {31'd0, Overflow}, 32'd0);
      check("rst_full",     {31'd0, Full},     32'd0);

      // Reset release while the strobe is already high: the byte is not captured.
      Rst_n = 1'b1;
      tick(5);
      check("held_rdy_valid", {31'd0, Valid}, 32'd0);
      check("held_rdy_count", {28'd0, Count}, 32'd0);

      // A fresh rising edge makes the byte visible on the third edge.
      RdyIn = 1'b0;
      tick(3);
      RdyIn = 1'b1;
      tick(1);
      check("lat_e1_valid", {31'd0, Valid}, 32'd0);
      tick(1);
      check("lat_e2_valid", {31'd0, Valid}, 32'd0);
      tick(1);
      check("lat_e3_valid", {31'd0, Valid}, 32'd1);
      check("lat_e3_dout",  {24'd0, Dout},  32'hA5);
      tick(2);
      RdyIn = 1'b0;
      tick(3);
      exp_q.push_back(8'hA5);
`ifdef RXBUF_PARITY_EN
      perr_q.push_back(1'b0);
`endif
      pop_check("lat_pop");
      check("lat_empty_count", {28'd0, Count}, 32'd0);

      // Four bytes, then a continuous drain.
      for (int i = 1; i <= 4; i++) begin
         send_byte(8'(i), 1'b0);
         exp_q.push_back(8'(i));
`ifdef RXBUF_PARITY_EN
         perr_q.push_back(1'b0);
`endif
      end
      check("four_count", {28'd0, Count}, 32'd4);
      for (int i = 0; i < 4; i++) begin
         exp_b = exp_q.pop_front();
         check("four_dout", {24'd0, Dout}, {24'd0, exp_b});
`ifdef RXBUF_PARITY_EN
         void'(perr_q.pop_front());
`endif
         Take = 1'b1;
         tick(1);
      end
      Take = 1'b0;
      check("four_valid_end", {31'd0, Valid}, 32'd0);
      check("four_count_end", {28'd0, Count}, 32'd0);

      // Fill to 8 entries, then a dropped 9th byte sets the sticky overflow.
      for (int i = 0; i < 8; i++) begin
         send_byte(8'h30 + 8'(i), 1'b0);
         exp_q.push_back(8'h30 + 8'(i));
`ifdef RXBUF_PARITY_EN
         perr_q.push_back(1'b0);
`endif
      end
      check("fill_count", {28'd0, Count}, 32'd8);
      check("fill_full",  {31'd0, Full},  32'd1);
      check("fill_ovf0",  {31'd0, Overflow}, 32'd0);
      send_byte(8'hFF, 1'b0);
      check("drop_ovf",   {31'd0, Overflow}, 32'd1);
      check("drop_count", {28'd0, Count},    32'd8);
      ClrOvf = 1'b1;
      tick(1);
      ClrOvf = 1'b0;
      check("clr_ovf", {31'd0, Overflow}, 32'd0);
      for (int i = 0; i < 8; i++) pop_check("drain1");
      check("drain1_count", {28'd0, Count}, 32'd0);

      // Full FIFO: a 9th write that coincides with a pop is accepted.
      for (int i = 0; i < 8; i++) begin
         send_byte(8'h50 + 8'(i), 1'b0);
         exp_q.push_back(8'h50 + 8'(i));
`ifdef RXBUF_PARITY_EN
         perr_q.push_back(1'b0);
`endif
      end
      PDin  = 8'hFF;
      RdyIn = 1'b1;
      tick(2);
      exp_b = exp_q.pop_front();
      check("simul_head", {24'd0, Dout}, {24'd0, exp_b});
`ifdef RXBUF_PARITY_EN
      void'(perr_q.pop_front());
`endif
      Take = 1'b1;
      tick(1);
      Take = 1'b0;
      exp_q.push_back(8'hFF);
`ifdef RXBUF_PARITY_EN
      perr_q.push_back(1'b0);
`endif
      check("simul_count", {28'd0, Count},    32'd8);
      check("simul_ovf",   {31'd0, Overflow}, 32'd0);
      check("simul_full",  {31'd0, Full},     32'd1);
      tick(2);
      RdyIn = 1'b0;
      tick(3);
      for (int i = 0; i < 8; i++) pop_check("drain2");
      check("drain2_valid", {31'd0, Valid}, 32'd0);

      // Empty FIFO with Take held across the write edge: Take is ignored.
      PDin  = 8'h77;
      RdyIn = 1'b1;
      tick(2);
      Take = 1'b1;
      tick(1);
      Take = 1'b0;
      check("emptytake_valid", {31'd0, Valid}, 32'd1);
      check("emptytake_count", {28'd0, Count}, 32'd1);
      check("emptytake_dout",  {24'd0, Dout},  32'h77);
      tick(2);
      RdyIn = 1'b0;
      tick(3);
      exp_q.push_back(8'h77);
`ifdef RXBUF_PARITY_EN
      perr_q.push_back(1'b0);
`endif
      pop_check("emptytake_pop");

      // A half-period glitch on RdyIn between edges is never captured.
      RdyIn = 1'b1;
      #4;
      RdyIn = 1'b0;
      tick(5);
      check("glitch_count", {28'd0, Count}, 32'd0);
      check("glitch_valid", {31'd0, Valid}, 32'd0);

      // A reset in the middle of a cycle discards stored bytes at once.
      for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0);
      check("pre_rst_count", {28'd0, Count}, 32'd5);
      #2;
      Rst_n = 1'b0;
      #1;
      check("async_rst_count", {28'd0, Count}, 32'd0);
      check("async_rst_valid", {31'd0, Valid}, 32'd0);
      check("async_rst_dout",  {24'd0, Dout},  32'd0);
      exp_q.delete();
`ifdef RXBUF_PARITY_EN
      perr_q.delete();
`endif
      tick(2);
      Rst_n = 1'b1;
      tick(5);
      check("post_rst_count", {28'd0, Count}, 32'd0);

`ifdef RXBUF_PARITY_EN
      // The parity flag travels with each byte.
      send_byte(8'h10, 1'b1);
      exp_q.push_back(8'h10);
      perr_q.push_back(1'b1);
      send_byte(8'h20, 1'b0);
      exp_q.push_back(8'h20);
      perr_q.push_back(1'b0);
      pop_check("par_first");
      pop_check("par_second");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
